iomem_timer: RTL and testbench

- Programmable timer peripheral and responder on the SoC's iomem bus (valid/ready, wstrb, addr, wdata, rdata).
- 32-bit up-counter with prescaler, compare match, one-shot and auto-reload modes.
- Level interrupt output intended for an irq_5..irq_7 input.
- Adds a memory-mapped timebase without touching CPU-side decode.

---
 rtl/iomem_timer_pkg.sv | 27 ++
 rtl/iomem_timer_prescaler.sv | 31 +++
 rtl/iomem_timer.sv | 126 ++++++++++++
 tb/tb_iomem_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_timer_pkg.sv
// Shared register map, CTRL bit positions and byte-strobe merge helper for the
// iomem timer peripheral.
package iomem_timer_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_PRESCALE = 8'h04;
    localparam logic [7:0] REG_COUNT    = 8'h08;
    localparam logic [7:0] REG_COMPARE  = 8'h0C;
    localparam logic [7:0] REG_STATUS   = 8'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_W      = 3;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Prescaler: pcnt runs 0..prescale while enabled, tick on the terminal value.
// Disabling or an explicit clear restarts the period from zero.
module iomem_timer_prescaler
    import iomem_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    // The tick is not masked by clear, so a CTRL/PRESCALE write can coincide with it.
    assign tick = en & (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (clear || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// Timer peripheral on the iomem bus: 32-bit counter with prescaler, compare
// match, one-shot/auto-reload and a level interrupt.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic [CTRL_W-1:0]     ctrl_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_nxt;
    logic [31:0]           count_q;
    logic [31:0]           compare_q;
    logic                  match_q;

    logic        sel;
    logic        acc;
    logic        wr_en;
    logic [5:0]  word;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        status_clr;
    logic        tick;
    logic        match_set;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign sel   = iomem_valid & (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign acc   = sel & ~iomem_ready;
    assign wr_en = acc & (|iomem_wstrb);
    assign word  = iomem_addr[7:2];
    assign unused_addr_bits = ^iomem_addr[1:0];

    assign wr_ctrl     = wr_en & (word == REG_CTRL[7:2]);
    assign wr_prescale = wr_en & (word == REG_PRESCALE[7:2]);
    assign wr_count    = wr_en & (word == REG_COUNT[7:2]);
    assign wr_compare  = wr_en & (word == REG_COMPARE[7:2]);
    assign wr_status   = wr_en & (word == REG_STATUS[7:2]);
    assign status_clr  = wr_status & iomem_wstrb[0] & iomem_wdata[0];

    assign match_set = tick & (count_q == compare_q);
    assign irq       = match_q & ctrl_q[CTRL_IRQ_EN];

    iomem_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_q[CTRL_EN]),
        .clear    (wr_ctrl | wr_prescale),
        .prescale (prescale_q),
        .tick     (tick)
    );

    always_comb begin
        prescale_nxt = prescale_q;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (iomem_wstrb[i/8]) prescale_nxt[i] = iomem_wdata[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            REG_CTRL[7:2]:     rd_mux = 32'(ctrl_q);
            REG_PRESCALE[7:2]: rd_mux = 32'(prescale_q);
            REG_COUNT[7:2]:    rd_mux = count_q;
            REG_COMPARE[7:2]:  rd_mux = compare_q;
            REG_STATUS[7:2]:   rd_mux = {31'b0, match_q};
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            ctrl_q      <= '0;
            prescale_q  <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            match_q     <= 1'b0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= (acc && iomem_wstrb == 4'b0000) ? rd_mux : 32'h0;

            // A bus write to CTRL overrides the one-shot auto-disable.
            if (wr_ctrl && iomem_wstrb[0]) begin
                ctrl_q <= iomem_wdata[CTRL_W-1:0];
            end else if (match_set && !ctrl_q[CTRL_AUTO]) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end

            if (wr_prescale) prescale_q <= prescale_nxt;
            if (wr_compare)  compare_q  <= apply_wstrb(compare_q, iomem_wdata, iomem_wstrb);

            if (wr_count) begin
                count_q <= apply_wstrb(count_q, iomem_wdata, iomem_wstrb);
            end else if (tick) begin
                if (count_q == compare_q) begin
                    if (ctrl_q[CTRL_AUTO]) count_q <= '0;
                end else begin
                    count_q <= count_q + 32'd1;
                end
            end

            // A new match on the clearing edge keeps MATCH set.
            match_q <= match_set | (match_q & ~status_clr);
        end
    end

endmodule

// File: tb/tb_iomem_timer.sv
// Directed bench for iomem_timer: bus handshake, register access, timer modes
// and same-edge collisions, with expected read data queued per transfer.
module tb_iomem_timer;
    import iomem_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          e0;
    logic [31:0] exp_q[$];

    iomem_timer dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One idle edge, then request; returns 1 time unit after the ack edge.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input string tag);
        int  lat;
        bit  got;
        logic [31:0] exp_v;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_rd);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        lat = 0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (iomem_ready) begin
                got = 1;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd1);
        exp_v = exp_q.pop_front();
        if (got) check({tag, " rdata"}, iomem_rdata, exp_v);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        xfer(BASE | 32'(off), 4'hF, d, 32'h0, $sformatf("wr%02h", off));
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp_rd, input string tag);
        xfer(BASE | 32'(off), 4'h0, 32'h0, exp_rd, tag);
    endtask

    initial begin
        int k;
        int seen;
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        idle(3);
        check("reset ready", 32'(iomem_ready), 32'd0);
        check("reset rdata", iomem_rdata, 32'h0);
        check("reset irq", 32'(irq), 32'd0);
        reset = 1'b0;

        for (int o = 0; o <= 16; o += 4) rd(8'(o), 32'h0, $sformatf("reset read %02h", o));
        check("reset irq after reads", 32'(irq), 32'd0);

        // Valid held for four cycles: ready alternates, never two in a row.
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'(REG_CTRL);
        iomem_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check($sformatf("held ready %0d", i), 32'(iomem_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        iomem_valid = 1'b0;
        idle(1);
        check("held ready after drop", 32'(iomem_ready), 32'd0);

        // Byte strobes and register widths.
        xfer(BASE | 32'(REG_COMPARE), 4'b0101, 32'hDEADBEEF, 32'h0, "strb wr");
        rd(REG_COMPARE, 32'h00AD00EF, "strb rd");
        xfer(BASE | 32'(REG_COMPARE), 4'b1010, 32'h11223344, 32'h0, "strb wr2");
        rd(REG_COMPARE, 32'h11AD33EF, "strb rd2");
        wr(REG_PRESCALE, 32'hFFFF1234);
        rd(REG_PRESCALE, 32'h00001234, "prescale width");
        wr(8'h14, 32'hFFFFFFFF);
        rd(8'h14, 32'h0, "unmapped");

        // Out-of-window request must never be acknowledged.
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0100;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h7;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (iomem_ready) seen++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        check("out of window ready", 32'(seen), 32'd0);
        rd(REG_CTRL, 32'h0, "out of window no write");

        // Auto-reload: tick every 4 cycles, match at tick 6 (24 cycles).
        wr(REG_PRESCALE, 32'd3);
        wr(REG_COMPARE, 32'd5);
        wr(REG_COUNT, 32'd0);
        wr(REG_CTRL, 32'h7);
        e0 = cyc;
        for (int i = 0; i < 14; i++) begin
            k = cyc + 1 - e0;
            rd(REG_COUNT, 32'((k / 4) % 6), $sformatf("auto count k=%0d", k));
            check($sformatf("auto irq t=%0d", cyc - e0), 32'(irq), (cyc - e0 >= 24) ? 32'd1 : 32'd0);
        end
        wr(REG_STATUS, 32'h1);
        check("auto irq cleared", 32'(irq), 32'd0);
        wr(REG_CTRL, 32'h0);

        // One-shot: three ticks to match, then EN drops and COUNT holds.
        wr(REG_COUNT, 32'd0);
        wr(REG_STATUS, 32'h1);
        wr(REG_PRESCALE, 32'd0);
        wr(REG_COMPARE, 32'd2);
        wr(REG_CTRL, 32'h5);
        rd(REG_STATUS, 32'h0, "oneshot status early");
        rd(REG_STATUS, 32'h1, "oneshot status match");
        check("oneshot irq", 32'(irq), 32'd1);
        rd(REG_CTRL, 32'h4, "oneshot ctrl");
        rd(REG_COUNT, 32'd2, "oneshot count");
        idle(6);
        rd(REG_COUNT, 32'd2, "oneshot count held");
        wr(REG_CTRL, 32'h0);
        wr(REG_STATUS, 32'h1);

        // COUNT write on the tick edge wins over the increment.
        wr(REG_COUNT, 32'd5);
        wr(REG_COMPARE, 32'h1000);
        wr(REG_PRESCALE, 32'd9);
        wr(REG_CTRL, 32'h3);
        idle(8);
        wr(REG_COUNT, 32'h100);
        rd(REG_COUNT, 32'h100, "count write vs tick");

        // STATUS clear on the match edge leaves MATCH set.
        wr(REG_CTRL, 32'h0);
        wr(REG_COUNT, 32'd3);
        wr(REG_COMPARE, 32'd3);
        wr(REG_STATUS, 32'h1);
        wr(REG_CTRL, 32'h3);
        idle(8);
        wr(REG_STATUS, 32'h1);
        rd(REG_STATUS, 32'h1, "status clear vs match");

        // CTRL write on a one-shot match edge keeps the written EN.
        wr(REG_CTRL, 32'h0);
        wr(REG_COUNT, 32'd3);
        wr(REG_STATUS, 32'h1);
        wr(REG_CTRL, 32'h1);
        idle(8);
        wr(REG_CTRL, 32'h5);
        rd(REG_CTRL, 32'h5, "ctrl write vs oneshot");
        rd(REG_STATUS, 32'h1, "ctrl collision match");
        check("irq before reset", 32'(irq), 32'd1);

        // Reset during the wait state of a COUNT write.
        idle(1);
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'(REG_COUNT);
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h55;
        reset       = 1'b1;
        idle(1);
        check("reset mid ready", 32'(iomem_ready), 32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        reset       = 1'b0;
        check("reset mid irq", 32'(irq), 32'd0);
        rd(REG_COUNT, 32'h0, "reset mid count");
        rd(REG_CTRL, 32'h0, "reset mid ctrl");
        rd(REG_STATUS, 32'h0, "reset mid status");

        // Wrap from all-ones to zero without a match.
        wr(REG_PRESCALE, 32'd0);
        wr(REG_COMPARE, 32'h10);
        wr(REG_COUNT, 32'hFFFF_FFFF);
        wr(REG_CTRL, 32'h1);
        rd(REG_COUNT, 32'h0, "wrap count");
        rd(REG_STATUS, 32'h0, "wrap no match");
        wr(REG_CTRL, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
